// File: rtl/neuron_pkg.sv
// Types, constants and helpers shared by the neuron and its synapse front end.
// All values are signed 2.16 fixed point.
package neuron_pkg;
    typedef logic signed [17:0] fx18_t;

    localparam fx18_t FX_MAX         = 18'sh1FFFF;
    localparam fx18_t FX_MIN         = 18'sh20000;
    localparam int    FX_FRAC        = 16;
    localparam fx18_t I_BIAS_DEFAULT = 18'sd9830;

    typedef enum logic [1:0] {
        IDLE,
        DECAY,
        ACCUM,
        PUBLISH
    } syn_state_t;

    // A 19-bit result overflowed 18 bits exactly when its top two bits differ.
    function automatic fx18_t fx_clamp19(input logic signed [18:0] v);
        if (v[18] != v[17]) begin
            return v[18] ? FX_MIN : FX_MAX;
        end
        return v[17:0];
    endfunction
endpackage

// File: rtl/fx_sat_add.sv
// Combinational saturating adder for 2.16 values, shared by the decay and
// accumulate steps of the synapse.
module fx_sat_add
    import neuron_pkg::*;
(
    input  fx18_t i_a,
    input  fx18_t i_b,
    output fx18_t o_sum
);
    logic signed [18:0] w_sumWide;

    assign w_sumWide = {i_a[17], i_a} + {i_b[17], i_b};
    assign o_sum     = fx_clamp19(w_sumWide);
endmodule

// File: rtl/spike_synapse.sv
// Synaptic current generator: latches presynaptic spikes per update period,
// decays the current toward the bias and adds the weights of the inputs that fired.
module spike_synapse
    import neuron_pkg::*;
#(
    parameter int    N_IN      = 4,
    parameter int    TICK_BITS = 12,
    parameter int    TAU_SHIFT = 3,
    parameter fx18_t I_BIAS    = I_BIAS_DEFAULT,
    localparam int   AW        = (N_IN > 1) ? $clog2(N_IN) : 1
)(
    input  logic            CLOCK_50,
    input  logic            reset,
    input  logic [N_IN-1:0] spike_in,
    input  logic            w_we,
    input  logic [AW-1:0]   w_addr,
    input  fx18_t           w_data,
    output logic            w_ready,
    output fx18_t           i_syn,
    output logic            i_valid,
    output logic            busy
);
    syn_state_t          r_state, w_stateNext;
    logic [TICK_BITS-1:0] r_count;
    logic [N_IN-1:0]     r_pending, r_snap;
    logic [AW-1:0]       r_idx;
    fx18_t               r_acc, r_iSyn;
    logic                r_iValid;
    fx18_t               r_weight [N_IN];

    logic                w_tick, w_lastIdx;
    logic signed [18:0]  w_diff, w_decay;
    fx18_t               w_decayNeg, w_addA, w_addB, w_addSum;

    assign w_tick    = (r_count == '0) && !reset;
    assign w_lastIdx = (r_idx == AW'(N_IN - 1));
    assign w_ready   = (r_state != ACCUM);
    assign busy      = (r_state != IDLE);
    assign i_syn     = r_iSyn;
    assign i_valid   = r_iValid;

    // Decay is expressed as i_syn + (-(i_syn - bias) >>> tau) so one adder serves both steps.
    assign w_diff     = {r_iSyn[17], r_iSyn} - {I_BIAS[17], I_BIAS};
    assign w_decay    = w_diff >>> TAU_SHIFT;
    assign w_decayNeg = fx_clamp19(-w_decay);

    always_comb begin
        w_addA = r_acc;
        w_addB = r_weight[r_idx];
        if (r_state == DECAY) begin
            w_addA = r_iSyn;
            w_addB = w_decayNeg;
        end
    end

    fx_sat_add u_add (
        .i_a   (w_addA),
        .i_b   (w_addB),
        .o_sum (w_addSum)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_tick) w_stateNext = DECAY;
            DECAY:   w_stateNext = ACCUM;
            ACCUM:   if (w_lastIdx) w_stateNext = PUBLISH;
            PUBLISH: w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Spikes arriving on the tick cycle seed the next period rather than the snapshot.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_count   <= '0;
            r_pending <= '0;
            r_snap    <= '0;
        end else begin
            r_count <= r_count + TICK_BITS'(1);
            if (w_tick) begin
                r_snap    <= r_pending;
                r_pending <= spike_in;
            end else begin
                r_pending <= r_pending | spike_in;
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_acc    <= I_BIAS;
            r_idx    <= '0;
            r_iSyn   <= I_BIAS;
            r_iValid <= 1'b0;
        end else begin
            r_iValid <= 1'b0;
            case (r_state)
                DECAY: begin
                    r_acc <= w_addSum;
                    r_idx <= '0;
                end
                ACCUM: begin
                    if (r_snap[r_idx]) r_acc <= w_addSum;
                    r_idx <= w_lastIdx ? '0 : r_idx + AW'(1);
                end
                PUBLISH: begin
                    r_iSyn   <= r_acc;
                    r_iValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int k = 0; k < N_IN; k++) r_weight[k] <= '0;
        end else if (w_we && w_ready && (int'(w_addr) < N_IN)) begin
            r_weight[w_addr] <= w_data;
        end
    end
endmodule

// File: tb/tb_spike_synapse.sv
// Scoreboard bench for spike_synapse: expected currents are queued when spikes
// and weights are driven and popped when the DUT pulses i_valid.
module tb_spike_synapse;
    import neuron_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] spike_in = '0;
    logic       w_we     = 1'b0;
    logic [1:0] w_addr   = '0;
    fx18_t      w_data   = '0;
    logic       w_ready;
    fx18_t      i_syn;
    logic       i_valid;
    logic       busy;

    int    testsRun    = 0;
    int    testsFailed = 0;
    fx18_t expQ[$];

    always #10 CLOCK_50 = ~CLOCK_50;

    spike_synapse #(
        .N_IN      (4),
        .TICK_BITS (12),
        .TAU_SHIFT (3),
        .I_BIAS    (18'sd9830)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .spike_in (spike_in),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_ready  (w_ready),
        .i_syn    (i_syn),
        .i_valid  (i_valid),
        .busy     (busy)
    );

    // Bounded wait for the next i_valid pulse, sampled on falling edges.
    task automatic wait_update(output int cycles, output bit got);
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 5000) begin
            @(negedge CLOCK_50);
            cycles++;
            if (i_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic pulse_spike(input logic [3:0] mask);
        spike_in = mask;
        @(negedge CLOCK_50);
        spike_in = '0;
    endtask

    task automatic write_weight(input int addr, input fx18_t data);
        w_we   = 1'b1;
        w_addr = 2'(addr);
        w_data = data;
        @(negedge CLOCK_50);
        w_we   = 1'b0;
    endtask

    task automatic restart();
        int cyc; bit got; fx18_t expVal;
        reset = 1'b1; spike_in = '0; w_we = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        expQ.push_back(18'sd9830);
        reset = 1'b0;
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || cyc !== 7 || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL restart: valid=%0b after %0d cycles i_syn=%0d, expected 7 cycles i_syn=%0d",
                     got, cyc, i_syn, expVal);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; spike_in = '0; w_we = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        testsRun++;
        if (i_syn !== 18'sd9830) begin
            testsFailed++;
            $display("[TB] FAIL reset_isyn: got %0d, expected 9830", i_syn);
        end
        testsRun++;
        if ({i_valid, w_ready, busy} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL reset_flags: valid/ready/busy=%b, expected 010", {i_valid, w_ready, busy});
        end
    endtask

    task automatic test_idle();
        int cyc; bit got; fx18_t expVal; logic [2:0] expBits;
        expQ.push_back(18'sd9830);
        expQ.push_back(18'sd9830);
        reset = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge CLOCK_50);
            expBits = {logic'(n <= 6), logic'(!(n >= 2 && n <= 5)), logic'(n == 7)};
            testsRun++;
            if ({busy, w_ready, i_valid} !== expBits) begin
                testsFailed++;
                $display("[TB] FAIL idle_timing cycle %0d: busy/ready/valid=%b, expected %b",
                         n, {busy, w_ready, i_valid}, expBits);
            end
        end
        expVal = expQ.pop_front();
        testsRun++;
        if (i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL idle_first: got %0d, expected %0d", i_syn, expVal);
        end
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || cyc !== 4095 || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL idle_period: valid=%0b after %0d cycles i_syn=%0d, expected 4095 cycles i_syn=%0d",
                     got, cyc, i_syn, expVal);
        end
    endtask

    task automatic test_single_spike();
        int cyc; bit got; fx18_t expVal;
        write_weight(0, 18'sd16384);
        pulse_spike(4'b0001);
        expQ.push_back(18'sd26214);
        expQ.push_back(18'sd24166);
        for (int k = 0; k < 2; k++) begin
            wait_update(cyc, got);
            expVal = expQ.pop_front();
            testsRun++;
            if (!got || i_syn !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL single_spike[%0d]: valid=%0b i_syn=%0d, expected %0d", k, got, i_syn, expVal);
            end
        end
    endtask

    task automatic test_saturation();
        int cyc; bit got; fx18_t expVal;
        for (int a = 0; a < 4; a++) write_weight(a, 18'sh1FFFF);
        pulse_spike(4'b1111);
        expQ.push_back(18'sd131071);
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL sat_pos: valid=%0b i_syn=%0d, expected %0d", got, i_syn, expVal);
        end
        for (int a = 0; a < 4; a++) write_weight(a, 18'sh20000);
        pulse_spike(4'b1111);
        expQ.push_back(-18'sd131072);
        expQ.push_back(-18'sd113459);
        for (int k = 0; k < 2; k++) begin
            wait_update(cyc, got);
            expVal = expQ.pop_front();
            testsRun++;
            if (!got || i_syn !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL sat_neg[%0d]: valid=%0b i_syn=%0d, expected %0d", k, got, i_syn, expVal);
            end
        end
    endtask

    task automatic test_spike_counting();
        int cyc; bit got; fx18_t expVal;
        restart();
        write_weight(1, 18'sd8192);
        pulse_spike(4'b0010);
        @(negedge CLOCK_50);
        pulse_spike(4'b0010);
        repeat (5) @(negedge CLOCK_50);
        pulse_spike(4'b0010);
        expQ.push_back(18'sd18022);
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL spike_once: valid=%0b i_syn=%0d, expected %0d", got, i_syn, expVal);
        end
        repeat (4089) @(negedge CLOCK_50);
        spike_in = 4'b0010;
        @(negedge CLOCK_50);
        spike_in = '0;
        expQ.push_back(18'sd16998);
        expQ.push_back(18'sd24294);
        for (int k = 0; k < 2; k++) begin
            wait_update(cyc, got);
            expVal = expQ.pop_front();
            testsRun++;
            if (!got || i_syn !== expVal) begin
                testsFailed++;
                $display("[TB] FAIL tick_boundary[%0d]: valid=%0b i_syn=%0d, expected %0d", k, got, i_syn, expVal);
            end
        end
    endtask

    task automatic test_write_accum();
        int cyc; bit got; fx18_t expVal; int lowCount;
        restart();
        pulse_spike(4'b0100);
        expQ.push_back(18'sd9830);
        repeat (4090) @(negedge CLOCK_50);
        w_we = 1'b1; w_addr = 2'd2; w_data = 18'sd4096;
        lowCount = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge CLOCK_50);
            if (w_ready === 1'b0) lowCount++;
        end
        testsRun++;
        if (lowCount !== 4 || w_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL accum_ready: low for %0d cycles, ready at publish=%b, expected 4 and 1",
                     lowCount, w_ready);
        end
        @(negedge CLOCK_50);
        w_we = 1'b0;
        expVal = expQ.pop_front();
        testsRun++;
        if (i_valid !== 1'b1 || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL accum_write_same_tick: valid=%b i_syn=%0d, expected 1 and %0d", i_valid, i_syn, expVal);
        end
        pulse_spike(4'b0100);
        expQ.push_back(18'sd13926);
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL accum_write_next_tick: valid=%0b i_syn=%0d, expected %0d", got, i_syn, expVal);
        end
    endtask

    task automatic test_reset_mid_accum();
        int cyc; bit got; fx18_t expVal;
        restart();
        write_weight(3, 18'sd4096);
        pulse_spike(4'b1000);
        expQ.push_back(18'sd13926);
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL pre_reset_update: valid=%0b i_syn=%0d, expected %0d", got, i_syn, expVal);
        end
        pulse_spike(4'b1000);
        repeat (4091) @(negedge CLOCK_50);
        testsRun++;
        if ({busy, w_ready} !== 2'b10) begin
            testsFailed++;
            $display("[TB] FAIL second_accum: busy/ready=%b, expected 10", {busy, w_ready});
        end
        reset = 1'b1;
        @(negedge CLOCK_50);
        testsRun++;
        if (i_syn !== 18'sd9830 || {busy, w_ready, i_valid} !== 3'b010) begin
            testsFailed++;
            $display("[TB] FAIL mid_reset: i_syn=%0d busy/ready/valid=%b, expected 9830 and 010",
                     i_syn, {busy, w_ready, i_valid});
        end
        reset = 1'b0;
        expQ.push_back(18'sd9830);
        expQ.push_back(18'sd9830);
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || cyc !== 7 || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL no_aborted_valid: valid=%0b after %0d cycles i_syn=%0d, expected 7 cycles i_syn=%0d",
                     got, cyc, i_syn, expVal);
        end
        pulse_spike(4'b1000);
        wait_update(cyc, got);
        expVal = expQ.pop_front();
        testsRun++;
        if (!got || i_syn !== expVal) begin
            testsFailed++;
            $display("[TB] FAIL weights_cleared: valid=%0b i_syn=%0d, expected %0d", got, i_syn, expVal);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_spike();
        test_saturation();
        test_spike_counting();
        test_write_accum();
        test_reset_mid_accum();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/spike_synapse.md
# spike_synapse

Synaptic current generator feeding a neuron's input current `I`. It collects one-cycle spike pulses from `N_IN` presynaptic neurons and applies a per-input signed weight to each. It decays the summed current toward a bias, and publishes a new 2.16 fixed-point current once per neuron update tick. This is the receive side of the neuron spike output: it turns spikes back into current for the next neuron stage.

## Interface
Parameters:
- `N_IN`, 4: number of presynaptic spike inputs; must satisfy `N_IN+3 < 2**TICK_BITS`.
- `TICK_BITS`, 12: update period is `2**TICK_BITS` cycles, matching the neuron update divider.
- `TAU_SHIFT`, 3: decay shift, so decay per tick is `(i_syn - I_BIAS) >>> TAU_SHIFT`.
- `I_BIAS`, 18'sd9830: resting current (0.15 in 2.16 format).

Ports:
- `CLOCK_50`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `spike_in`  in  N_IN  one-cycle spike pulses, one bit per presynaptic neuron.
- `w_we`  in  1  weight write request.
- `w_addr`  in  $clog2(N_IN)  weight index.
- `w_data`  in  18  signed 2.16 weight.
- `w_ready`  out  1  write accepted when `w_we && w_ready`.
- `i_syn`  out  18  signed 2.16 synaptic current; feeds the neuron's `I`.
- `i_valid`  out  1  one-cycle pulse when `i_syn` updates.
- `busy`  out  1  high outside IDLE.

## Operation
- **Number format:** all values are signed 18-bit, 16 fractional bits, range [-2.0, 2.0).
- **Saturation:** every add saturates to 0x1FFFF / 0x20000.
- **Spike capture:** `pending[k]` sets on any cycle with `spike_in[k]=1`.
  - Multiple spikes on one input within one period count once.
- **Tick counter:** `count` (TICK_BITS wide) increments every non-reset cycle and wraps.
  - A tick is a cycle with `count==0` and `reset` low.
- **On tick:**
  - `snap <= pending`.
  - `pending <= spike_in`, so a spike arriving on the tick cycle belongs to the next period.
  - FSM goes IDLE→DECAY.
- **FSM:**
  - IDLE: wait for tick.
  - DECAY (1 cycle): `acc <= i_syn - ((i_syn - I_BIAS) >>> TAU_SHIFT)`, computed at 19 bits, then saturated.
  - ACCUM (`N_IN` cycles, `idx` 0..N_IN-1): if `snap[idx]`, `acc <= sat(acc + w[idx])`; after `idx==N_IN-1`, go to PUBLISH.
  - PUBLISH (1 cycle): `i_syn <= acc`, `i_valid <= 1`, then IDLE.
- **Weights:** `N_IN`×18 register file.
  - `w_ready` = (state != ACCUM).
  - An accepted write updates `w[w_addr]` on that clock edge.
  - A write held during ACCUM lands on the first cycle `w_ready` returns.
  - Writing index `idx` in DECAY is allowed and is used in the same tick.
- **Reset values:**
  - `i_syn=I_BIAS`, `i_valid=0`, `w_ready=1`, `busy=0`.
  - All weights 0; `pending`, `snap`, `count`, `idx` all 0; state IDLE.
- **Reset mid-operation:** aborts the current update with no `i_valid`; all state returns to reset values on the next edge.

## Timing
- The first tick is the first cycle after `reset` deasserts; later ticks follow every `2**TICK_BITS` cycles.
- **Latency:** with the tick in cycle T:
  - DECAY occupies T+1.
  - ACCUM occupies T+2..T+N_IN+1.
  - PUBLISH occupies T+N_IN+2.
  - `i_valid` and the new `i_syn` are visible from T+N_IN+3.
- `i_syn` is registered and holds its value between updates.
- `busy` is high from T+1 through PUBLISH.
- `w_ready` is low exactly during the `N_IN` ACCUM cycles.
- `spike_in` is sampled every cycle, including while busy; pending capture never stalls.

## Structure
- **Shared package `neuron_pkg`:**
  - `typedef logic signed [17:0] fx18_t`.
  - Constants `FX_MAX=18'sh1FFFF`, `FX_MIN=18'sh20000`, `FX_FRAC=16`.
  - FSM state enum {IDLE, DECAY, ACCUM, PUBLISH}.
  - `I_BIAS` default, shared with the neuron.
- **Sub-module `fx_sat_add`:** combinational saturating 18-bit signed adder (a+b, 19-bit internal, clamped). It is used by the DECAY and ACCUM paths.

## Test plan
Defaults for all scenarios: `N_IN=4`, `TAU_SHIFT=3`, `I_BIAS=9830`.
- **Idle:** reset, then no spikes → `i_valid` at cycle 7 after release and every 4096 cycles; `i_syn` stays 9830.
- **Single spike, then decay:**
  - Stimulus: write `w[0]=16384`; pulse `spike_in[0]` mid-period.
  - Next update: `i_syn=26214`.
  - Following update, no spikes: `i_syn=26214-2048=24166`.
- **Saturation:**
  - All weights 0x1FFFF and all four inputs spiking → `i_syn=131071`.
  - All weights -131072 and all spiking → `i_syn=-131072`.
- **Spike counting and period boundary:**
  - Stimulus: `w[1]=8192`.
  - Three pulses on input 1 in one period → +8192 once.
  - A pulse exactly on the tick cycle → counted in the following update, not the current one.
- **Write during ACCUM:**
  - Stimulus: `w_we` asserted for `w[2]=4096` during ACCUM.
  - Required: `w_ready=0` for 4 cycles; the write lands on the PUBLISH cycle; it affects the next tick only.
- **Reset mid-ACCUM:** assert `reset` in the second ACCUM cycle → next edge gives `i_syn=9830`, `busy=0`, all weights 0, and no `i_valid` pulse.
